// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and op-class helpers for the M-extension unit.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle native multiply).
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN,
    DONE
  } muldiv_state_t;

  function automatic logic is_div(muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_high(muldiv_op_t op);
    return op[1:0] != 2'b00;
  endfunction

  function automatic logic is_rem(muldiv_op_t op);
    return op[1];
  endfunction

  function automatic logic signed_op1(muldiv_op_t op);
    return (op == MULH) | (op == MULHSU) |
           (op == DIV) | (op == REM);
  endfunction

  function automatic logic signed_op2(muldiv_op_t op);
    return (op == MULH) | (op == DIV) | (op == REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: E-stage request/response bundle for the mul/div unit.
// Optional feature macro: MULDIV_FAST_MUL_EN (no effect on this bundle).
interface muldiv_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic             StartE;
  muldiv_op_t       MulDivOpE;
  logic [WIDTH-1:0] Op1E;
  logic [WIDTH-1:0] Op2E;
  logic             FlushE;
  logic             BusyE;
  logic             DoneE;
  logic [WIDTH-1:0] MulDivResultE;

  modport master (
    output StartE, MulDivOpE, Op1E, Op2E, FlushE,
    input  BusyE, DoneE, MulDivResultE
  );

  modport slave (
    input  StartE, MulDivOpE, Op1E, Op2E, FlushE,
    output BusyE, DoneE, MulDivResultE
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring divide iteration.
// Optional feature macro: MULDIV_FAST_MUL_EN (no effect on this block).
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               div_mode,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Multiply adds into the high half then shifts right; divide shifts
  // left and subtracts, leaving bit 0 free for the quotient bit.
  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
           + {1'b0, operand & {WIDTH{acc[0]}}};
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = rem_sh - {1'b0, operand};
    q_bit  = 1'b0;
    acc_nxt = {sum, acc[WIDTH-1:1]};
    if (div_mode) begin
      q_bit   = ~diff[WIDTH];
      acc_nxt = {q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0],
                 acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with pipeline stall.
// Optional feature macro: MULDIV_FAST_MUL_EN (native multiply, skips RUN).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  muldiv_state_t state_q, state_d;
  muldiv_op_t    op_q;
  logic          s1_q, s2_q, zero_q;
  logic [WIDTH-1:0] b_q, raw1_q, result_q;
  logic [W2-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;

  logic             start, last, fast;
  logic             sg1, sg2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [W2-1:0]    step_acc;
  logic             step_q;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo, rem, fin_res;

  assign start = bus.StartE & ~bus.FlushE &
                 ((state_q == IDLE) | (state_q == DONE));
  assign last  = cnt_q == CW'(WIDTH - 1);
  assign sg1   = signed_op1(bus.MulDivOpE) & bus.Op1E[WIDTH-1];
  assign sg2   = signed_op2(bus.MulDivOpE) & bus.Op2E[WIDTH-1];
  assign mag1  = sg1 ? -bus.Op1E : bus.Op1E;
  assign mag2  = sg2 ? -bus.Op2E : bus.Op2E;

`ifdef MULDIV_FAST_MUL_EN
  assign fast = ~is_div(bus.MulDivOpE);
`else
  assign fast = 1'b0;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .operand  (b_q),
    .div_mode (is_div(op_q)),
    .acc_nxt  (step_acc),
    .q_bit    (step_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: flush overrides everything, including a new start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? (fast ? FIN : RUN) : IDLE;
      RUN:        if (last) state_d = FIN;
      FIN:        state_d = DONE;
      default:    state_d = IDLE;
    endcase
    if (bus.FlushE) state_d = IDLE;
  end

  assign bus.BusyE = (state_q == RUN) | (state_q == FIN) | start;
  assign bus.DoneE = (state_q == DONE) & ~bus.FlushE;
  assign bus.MulDivResultE = result_q;

  // Sign fixup and result-half selection for the FIN cycle.
  always_comb begin
    prod = (s1_q ^ s2_q) ? -acc_q : acc_q;
    quo  = (s1_q ^ s2_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = s1_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    if (zero_q) begin
      quo = '1;
      rem = raw1_q;
    end
    fin_res = is_high(op_q) ? prod[W2-1:WIDTH] : prod[WIDTH-1:0];
    if (is_div(op_q)) fin_res = is_rem(op_q) ? rem : quo;
  end

  // Operand capture, iteration and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= MUL;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      zero_q   <= 1'b0;
      b_q      <= '0;
      raw1_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (start) begin
      op_q   <= bus.MulDivOpE;
      s1_q   <= sg1;
      s2_q   <= sg2;
      zero_q <= bus.Op2E == '0;
      b_q    <= mag2;
      raw1_q <= bus.Op1E;
      cnt_q  <= '0;
      acc_q  <= {{WIDTH{1'b0}}, mag1};
`ifdef MULDIV_FAST_MUL_EN
      if (fast) acc_q <= W2'(mag1) * W2'(mag2);
`endif
    end else if (state_q == RUN) begin
      acc_q <= step_acc | W2'(step_q);
      cnt_q <= cnt_q + CW'(1);
    end else if ((state_q == FIN) && !bus.FlushE) begin
      result_q <= fin_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit.
// Honours MULDIV_FAST_MUL_EN when computing expected multiply latency.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  logic [W-1:0] last_res = '0;

  function automatic int lat(muldiv_op_t op);
`ifdef MULDIV_FAST_MUL_EN
    return is_div(op) ? W + 2 : 2;
`else
    return W + 2;
`endif
  endfunction

  function automatic logic [W-1:0] ref_model(muldiv_op_t op,
                                             logic [W-1:0] a,
                                             logic [W-1:0] b);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      DIV: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == '1) return a;
        return 32'(sa / sb);
      end
      DIVU: return (b == 0) ? '1 : a / b;
      REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == '1) return '0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Scoreboard: every DoneE pops one expectation (value and cycle).
  always @(negedge clk) begin
    if (!reset && bus.DoneE) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d got=%h", cyc,
                 bus.MulDivResultE);
      end else begin
        logic [W-1:0] e;
        int c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        if (bus.MulDivResultE !== e) begin
          errors++;
          $display("FAIL result cyc=%0d got=%h exp=%h", cyc,
                   bus.MulDivResultE, e);
        end
        checks++;
        if (cyc !== c) begin
          errors++;
          $display("FAIL latency got_cyc=%0d exp_cyc=%0d", cyc, c);
        end
        last_res = e;
      end
    end
  end

  // Called at posedge+2; leaves at posedge+2 of the following cycle.
  task automatic issue(muldiv_op_t op, logic [W-1:0] a,
                       logic [W-1:0] b, logic [W-1:0] e);
    bus.StartE    = 1'b1;
    bus.MulDivOpE = op;
    bus.Op1E      = a;
    bus.Op2E      = b;
    exp_q.push_back(e);
    cyc_q.push_back(cyc + lat(op));
    #1;
    checks++;
    if (bus.BusyE !== 1'b1) begin
      errors++;
      $display("FAIL busy_on_start op=%s got=%b exp=1", op.name(),
               bus.BusyE);
    end
    @(posedge clk);
    #2;
    bus.StartE = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout pending=%0d exp=0", exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  task automatic run(muldiv_op_t op, logic [W-1:0] a,
                     logic [W-1:0] b, logic [W-1:0] e);
    issue(op, a, b, e);
    drain();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.BusyE !== 1'b0 || bus.DoneE !== 1'b0 ||
        bus.MulDivResultE !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b res=%h exp=0/0/0",
               bus.BusyE, bus.DoneE, bus.MulDivResultE);
    end
    #1;
  endtask

  task automatic test_mul_busy();
    int t, l, n;
    t = cyc;
    l = lat(MUL);
    n = 0;
    issue(MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    while (exp_q.size() != 0 && n < 200) begin
      checks++;
      if (bus.BusyE !== (cyc < t + l)) begin
        errors++;
        $display("FAIL busy_window cyc=%0d got=%b exp=%b", cyc - t,
                 bus.BusyE, cyc < t + l);
      end
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (bus.BusyE !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mul_end busy=%b pending=%0d exp=0/0",
               bus.BusyE, exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  task automatic test_mul_high();
    run(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_div();
    run(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run(DIVU, 32'd100, 32'd7, 32'd14);
    run(REMU, 32'd100, 32'd7, 32'd2);
  endtask

  task automatic test_div_zero();
    run(DIV,  32'd5, 32'd0, 32'hFFFF_FFFF);
    run(REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    run(DIVU, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
  endtask

  task automatic test_overflow();
    run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    issue(DIVU, 32'd1000, 32'd9, 32'd111);
    while (bus.DoneE !== 1'b1 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (bus.DoneE !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done got=%b exp=1", bus.DoneE);
    end
    issue(REMU, 32'd1000, 32'd9, 32'd1);
    drain();
  endtask

  task automatic test_flush();
    logic [W-1:0] prev;
    prev = last_res;
    issue(DIV, 32'd77, 32'd3, 32'd25);
    repeat (9) begin
      @(posedge clk);
      #2;
    end
    bus.FlushE = 1'b1;
    void'(exp_q.pop_back());
    void'(cyc_q.pop_back());
    @(posedge clk);
    #2;
    bus.FlushE = 1'b0;
    #1;
    checks++;
    if (bus.BusyE !== 1'b0 || bus.DoneE !== 1'b0 ||
        bus.MulDivResultE !== prev) begin
      errors++;
      $display("FAIL flush_abort busy=%b done=%b res=%h exp=0/0/%h",
               bus.BusyE, bus.DoneE, bus.MulDivResultE, prev);
    end
    @(posedge clk);
    #2;
    run(MUL, 32'd3, 32'd5, 32'd15);
    bus.StartE = 1'b1;
    bus.FlushE = 1'b1;
    bus.MulDivOpE = DIVU;
    #1;
    checks++;
    if (bus.BusyE !== 1'b0) begin
      errors++;
      $display("FAIL flush_prio_busy got=%b exp=0", bus.BusyE);
    end
    @(posedge clk);
    #2;
    bus.StartE = 1'b0;
    bus.FlushE = 1'b0;
    #1;
    checks++;
    if (bus.BusyE !== 1'b0) begin
      errors++;
      $display("FAIL flush_prio_idle got=%b exp=0", bus.BusyE);
    end
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    issue(REMU, 32'd12345, 32'd10, 32'd5);
    repeat (4) begin
      @(posedge clk);
      #2;
    end
    reset = 1'b1;
    void'(exp_q.pop_back());
    void'(cyc_q.pop_back());
    @(posedge clk);
    #1;
    checks++;
    if (bus.BusyE !== 1'b0 || bus.DoneE !== 1'b0 ||
        bus.MulDivResultE !== '0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b res=%h exp=0/0/0",
               bus.BusyE, bus.DoneE, bus.MulDivResultE);
    end
    #1;
    reset = 1'b0;
    last_res = '0;
    run(MULHU, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      muldiv_op_t op;
      logic [W-1:0] a, b;
      op = muldiv_op_t'(3'($urandom_range(0, 7)));
      a = pick();
      b = pick();
      run(op, a, b, ref_model(op, a, b));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.StartE    = 1'b0;
    bus.FlushE    = 1'b0;
    bus.MulDivOpE = MUL;
    bus.Op1E      = '0;
    bus.Op2E      = '0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    test_reset();
    test_mul_busy();
    test_mul_high();
    test_div();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
